// File: rtl/fact_pkg.sv
// Shared state encoding and default widths for the factorial engine.
package fact_pkg;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_N_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/factorial_engine.sv
// Iterative n! engine, one multiply per cycle: done one cycle after the max(n,1)-th edge past accept.
// No backpressure; start is only honoured in IDLE, and result/overflow hold until the next accepted start.
module factorial_engine
   import fact_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int N_WIDTH = DEF_N_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_WIDTH-1:0] n_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               overflow
);

   state_t             state_q, state_d;
   logic [N_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               overflow_q, overflow_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] prod;

   // Full-width product so any spill into the upper half is visible for the sticky flag.
   assign prod = {{WIDTH{1'b0}}, acc_q} * {{(2*WIDTH-N_WIDTH){1'b0}}, cnt_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = MUL;
               cnt_d      = n_in;
               acc_d      = WIDTH'(1);
               ovf_d      = 1'b0;
               result_d   = '0;
               overflow_d = 1'b0;
            end
         end
         MUL: begin
            if (cnt_q > N_WIDTH'(1)) begin
               acc_d = prod[WIDTH-1:0];
               cnt_d = cnt_q - N_WIDTH'(1);
               if (|prod[2*WIDTH-1:WIDTH]) begin
                  ovf_d = 1'b1;
               end
            end else begin
               result_d   = acc_q;
               overflow_d = ovf_q;
               state_d    = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == MUL);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine with a cycle-level reference model and per-cycle compare.
module tb_factorial_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  n_in = 8'd0;
   logic        busy, done, overflow;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   factorial_engine #(.WIDTH(32), .N_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .n_in(n_in),
      .busy(busy), .done(done), .result(result), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // {overflow, n! mod 2^32}; overflow means the true n! does not fit in 32 bits.
   function automatic logic [32:0] fact_model(input int n);
      logic [63:0] res = 64'd1;
      logic [63:0] exact = 64'd1;
      bit          big = 1'b0;
      for (int k = 2; k <= n; k++) begin
         res = (res * 64'(k)) & 64'hFFFF_FFFF;
         if (!big) begin
            exact = exact * 64'(k);
            if (exact > 64'hFFFF_FFFF) big = 1'b1;
         end
      end
      return {big, res[31:0]};
   endfunction

   // Reference model: idle / computing for max(n,1) cycles / one done cycle.
   int          m_phase = 0;
   int          m_rem = 0;
   logic        e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
   logic [31:0] e_res = 32'd0;
   logic [32:0] m_pending = 33'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0; m_rem <= 0;
         e_busy <= 1'b0; e_done <= 1'b0; e_res <= 32'd0; e_ovf <= 1'b0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_phase   <= 1;
               m_rem     <= (n_in < 8'd2) ? 1 : int'(n_in);
               m_pending <= fact_model(int'(n_in));
               e_busy <= 1'b1; e_done <= 1'b0; e_res <= 32'd0; e_ovf <= 1'b0;
            end
            1: begin
               if (m_rem <= 1) begin
                  m_phase <= 2;
                  e_busy <= 1'b0; e_done <= 1'b1;
                  e_res <= m_pending[31:0]; e_ovf <= m_pending[32];
               end else begin
                  m_rem <= m_rem - 1;
               end
            end
            default: begin
               m_phase <= 0;
               e_done  <= 1'b0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("result", result, e_res);
         chk("overflow", overflow, e_ovf);
         chk("busy_and_done", busy & done, 1'b0);
      end
   end

   // Called at a negedge with the engine idle; returns at the negedge after the done cycle.
   task automatic run(input int n, input logic [31:0] res_l, input logic ovf_l);
      int lat, bc, exp_lat;
      exp_lat = (n < 2) ? 1 : n;
      start = 1'b1; n_in = n[7:0];
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      bc  = busy ? 1 : 0;
      while (!done && lat < 600) begin
         @(negedge clk);
         lat++;
         if (busy) bc++;
      end
      chk($sformatf("done_seen_n%0d", n), done, 1'b1);
      chk($sformatf("latency_n%0d", n), lat - 1, exp_lat);
      chk($sformatf("busy_cycles_n%0d", n), bc, exp_lat);
      chk($sformatf("result_lit_n%0d", n), result, res_l);
      chk($sformatf("overflow_lit_n%0d", n), overflow, ovf_l);
      @(negedge clk);
   endtask

   initial begin
      int dcount, cyc, nd;
      int dt[3];

      chk("model_7", fact_model(7), {1'b0, 32'd5040});
      chk("model_12", fact_model(12), {1'b0, 32'd479001600});
      chk("model_13", fact_model(13), {1'b1, 32'd1932053504});
      chk("model_0", fact_model(0), {1'b0, 32'd1});

      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 32'd0);
      chk("rst_overflow", overflow, 1'b0);

      // Start in the first idle cycle after reset.
      run(7, 32'd5040, 1'b0);
      run(0, 32'd1, 1'b0);
      run(1, 32'd1, 1'b0);
      run(2, 32'd2, 1'b0);
      run(12, 32'd479001600, 1'b0);
      run(13, 32'd1932053504, 1'b1);
      run(255, 32'd0, 1'b1);

      // Second start while busy must not disturb the running n=7.
      start = 1'b1; n_in = 8'd7;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; n_in = 8'd3;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!done && cyc < 50) begin @(negedge clk); cyc++; end
      chk("ignored_start_done", done, 1'b1);
      chk("ignored_start_result", result, 32'd5040);
      @(negedge clk);

      // Reset mid-computation aborts with no done pulse.
      start = 1'b1; n_in = 8'd10;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_result", result, 32'd0);
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      run(5, 32'd120, 1'b0);

      // start held high: back-to-back runs every 6 cycles.
      start = 1'b1; n_in = 8'd4;
      nd = 0; cyc = 0;
      while (nd < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            dt[nd] = cyc;
            nd++;
            chk("held_result", result, 32'd24);
         end
      end
      start = 1'b0;
      chk("held_pulses", nd, 3);
      if (nd == 3) begin
         chk("held_period_1", dt[1] - dt[0], 6);
         chk("held_period_2", dt[2] - dt[1], 6);
      end
      cyc = 0;
      while ((busy || done) && cyc < 20) begin @(negedge clk); cyc++; end
      chk("held_drained", busy | done, 1'b0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
